// File: rtl/alu.sv
// Registered MIPS-style ALU (AND/OR/ADD/SUB/SLT) with zero flag; 1-cycle latency.
// No handshake or backpressure: a new operation is accepted and evaluated every cycle.
module alu #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] result,
   output logic             zero
);

   typedef enum logic [2:0] {
      OP_AND = 3'b000,
      OP_OR  = 3'b001,
      OP_ADD = 3'b010,
      OP_SUB = 3'b110,
      OP_SLT = 3'b111
   } op_e;

   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

   logic [WIDTH-1:0] result_q, result_d;
   logic             zero_q, zero_d;
   logic [WIDTH-1:0] diff;
   logic             ovf;
   logic             lt;

   always_comb begin
      diff = a + ~b + ONE;
      // Signed overflow on a-b: operand signs differ and the difference takes b's sign.
      ovf  = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      lt   = diff[WIDTH-1] ^ ovf;

      result_d = '0;
      case (op)
         OP_AND:  result_d = a & b;
         OP_OR:   result_d = a | b;
         OP_ADD:  result_d = a + b;
         OP_SUB:  result_d = diff;
         OP_SLT:  result_d = {{(WIDTH-1){1'b0}}, lt};
         default: result_d = '0;
      endcase
      zero_d = (result_d == '0);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         result_q <= '0;
         zero_q   <= 1'b1;
      end else begin
         result_q <= result_d;
         zero_q   <= zero_d;
      end
   end

   assign result = result_q;
   assign zero   = zero_q;

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed test-plan vectors then randomized stimulus
// against an integer-arithmetic reference model.
module tb_alu;

   localparam int W = 4;

   logic         clk;
   logic         reset;
   logic [2:0]   op;
   logic [W-1:0] a, b;
   logic [W-1:0] result;
   logic         zero;

   int vectors     = 0;
   int miscompares = 0;

   alu #(.WIDTH(W)) dut (
      .clk    (clk),
      .reset  (reset),
      .op     (op),
      .a      (a),
      .b      (b),
      .result (result),
      .zero   (zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h (op=%b a=%b b=%b)", tag, got, exp, op, a, b);
      end
   endtask

   function automatic int to_signed(input int v);
      return (v >= (1 << (W-1))) ? v - (1 << W) : v;
   endfunction

   function automatic int ref_result(input logic r, input int o, input int x, input int y);
      int m;
      m = 1 << W;
      if (r) return 0;
      case (o)
         0:       return x & y;
         1:       return x | y;
         2:       return (x + y) % m;
         6:       return (x - y + m) % m;
         7:       return (to_signed(x) < to_signed(y)) ? 1 : 0;
         default: return 0;
      endcase
   endfunction

   // Applies one set of inputs across one edge, checks the registered outputs, then
   // wiggles the inputs and confirms the outputs hold until the next edge.
   task automatic apply(input logic r, input logic [2:0] o, input logic [W-1:0] x,
                        input logic [W-1:0] y, input string tag);
      int exp_r;
      reset = r; op = o; a = x; b = y;
      exp_r = ref_result(r, int'(o), int'(x), int'(y));
      @(posedge clk);
      #1;
      chk({tag, ".result"}, 32'(result), 32'(exp_r));
      chk({tag, ".zero"},   32'(zero),   32'(exp_r == 0));
      op = 3'($urandom); a = W'($urandom); b = W'($urandom);
      #2;
      chk({tag, ".hold"}, 32'(result), 32'(exp_r));
   endtask

   logic [2:0]   d_op [11] = '{3'b000, 3'b001, 3'b010, 3'b010, 3'b110, 3'b110,
                               3'b110, 3'b111, 3'b111, 3'b111, 3'b111};
   logic [W-1:0] d_a  [11] = '{4'b0111, 4'b0101, 4'b0101, 4'b1111, 4'b0101, 4'b1111,
                               4'b0011, 4'b0101, 4'b1110, 4'b0111, 4'b1000};
   logic [W-1:0] d_b  [11] = '{4'b0001, 4'b0010, 4'b0001, 4'b0001, 4'b0001, 4'b0001,
                               4'b0011, 4'b0001, 4'b1111, 4'b1000, 4'b0111};

   initial begin
      reset = 1'b1; op = 3'b010; a = 4'b0111; b = 4'b0001;

      apply(1'b1, 3'b010, 4'b0111, 4'b0001, "reset");
      apply(1'b0, 3'b010, 4'b0111, 4'b0001, "post_reset_add");
      chk("post_reset_literal", 32'(result), 32'(4'b1000));

      // Test-plan vectors back to back, no idle cycles between them.
      for (int i = 0; i < 11; i++)
         apply(1'b0, d_op[i], d_a[i], d_b[i], $sformatf("dir%0d", i));

      apply(1'b0, 3'b011, 4'b1111, 4'b1111, "unused011");
      apply(1'b0, 3'b100, 4'b1111, 4'b1111, "unused100");
      apply(1'b0, 3'b101, 4'b1111, 4'b1111, "unused101");

      // Reset arriving mid-stream wins over a live operation.
      apply(1'b0, 3'b001, 4'b1010, 4'b0101, "pre_mid_reset");
      apply(1'b1, 3'b001, 4'b1010, 4'b0101, "mid_reset");

      // Exhaustive signed compare sweep.
      for (int x = 0; x < (1 << W); x++)
         for (int y = 0; y < (1 << W); y++)
            apply(1'b0, 3'b111, W'(x), W'(y), "slt_sweep");

      for (int i = 0; i < 400; i++)
         apply(($urandom_range(0, 19) == 0), 3'($urandom), W'($urandom), W'($urandom), "rand");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
